ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high.
REQ-002 SHALL have aluop_i in 8 (operation code; bit 7 = 1 selects the immediate operand) and alusel_i in 3 (result class: NOP, LOGIC, SHIFT, ARITH, JUMP, DIV).
REQ-003 SHALL have reg1_i in 32 (operand A) and reg2_i in 32 (register operand B).
REQ-004 SHALL have imm_i in 32 (sign-extended immediate) and shamt_i in 5 (immediate shift amount).
REQ-005 SHALL have wd_i in 5 (destination register), wreg_i in 1 (write-enable request) and link_addr_i in 17 (return address for JAL/JALR).
REQ-006 SHALL have flush_i in 1, which kills the in-flight instruction.
REQ-007 SHALL have wd_o out 5, wreg_o out 1, wdata_o out 32 and stallreq_o out 1 (requests that upstream registers hold).

Function
REQ-008 Operand B SHALL be imm_i when aluop_i[7]=1, else reg2_i.
REQ-009 Shift amount SHALL be shamt_i when aluop_i[7]=1, else reg2_i[4:0].
REQ-010 LOGIC class SHALL produce AND, OR or XOR, and LUI (result = operand B), in the same cycle.
REQ-011 SHIFT class SHALL produce SLL, SRL or SRA (SRA sign-fills from reg1_i[31]) in the same cycle.
REQ-012 ARITH class SHALL produce ADD, SUB (32-bit wrap, no overflow trap), SLT (signed) or SLTU (unsigned), with result 0 or 1.
REQ-013 JUMP class SHALL produce wdata_o = {15'b0, link_addr_i}.
REQ-014 NOP class or an unknown code SHALL produce wdata_o=0 and wreg_o=0.
REQ-015 wd_o SHALL equal wd_i, and wreg_o SHALL equal wreg_i, except that wreg_o SHALL be forced to 0 when wd_i=0, stallreq_o=1, flush_i=1 or rst=1.
REQ-016 DIV class (DIV, DIVU, REM, REMU) SHALL use a registered FSM with states IDLE, BUSY and DONE.
REQ-017 IDLE + DIV op + no flush -> if divisor=0 or signed overflow (0x80000000 / -1), go to DONE with the result preloaded; else load the magnitudes and a 6-bit counter=0 and go to BUSY; stallreq_o=1 in that cycle.
REQ-018 In BUSY, each cycle SHALL perform one restoring shift-subtract step and increment the counter; after step 32, go to DONE; stallreq_o=1 throughout.
REQ-019 In DONE, the result SHALL drive wdata_o, stallreq_o=0, and the next state SHALL be IDLE.
REQ-020 Signed fixup: quotient negated if operand signs differ; remainder takes the sign of the dividend.
REQ-021 Divide-by-zero SHALL give quotient 0xFFFFFFFF and remainder = dividend.
REQ-022 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-023 Latency SHALL be 34 cycles (normal) or 2 cycles (special case) from the first cycle of presentation to the DONE cycle, inclusive.
REQ-024 Inputs SHALL be held stable by upstream while stallreq_o=1; the block SHALL sample operands only in IDLE.
REQ-025 flush_i=1 in any state SHALL force the next state to IDLE and make stallreq_o=0 combinationally; flush wins over DONE completion.
REQ-026 A DIV op with wd_i=0 SHALL still run to completion with no write.
REQ-027 Back-to-back DIV ops SHALL each take the full latency; a DIV op presented in the DONE cycle SHALL start only after the return to IDLE.

Reset
REQ-028 With rst=1 at a rising edge, the FSM SHALL go to IDLE, counter=0 and the internal quotient and remainder registers=0.
REQ-029 While rst=1, wd_o=0, wreg_o=0, wdata_o=0 and stallreq_o=0, even if asserted mid-division.

Verification
REQ-030 ADD with aluop_i[7]=1, reg1=5, imm=0xFFFFFFFD, wd=3, wreg=1 -> same cycle wdata=2, wd=3, wreg=1, stallreq=0.
REQ-031 SRA with reg1=0x80000000, reg2=4 -> wdata=0xF8000000; SLTU with reg1=1, reg2=0xFFFFFFFF -> wdata=1.
REQ-032 DIV -7/2 -> stallreq=1 for 33 cycles, then DONE with wdata=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-033 DIVU x/0 -> 2-cycle latency, quotient 0xFFFFFFFF; REM 0x80000000/-1 -> remainder 0.
REQ-034 flush_i asserted at BUSY step 10 -> stallreq=0 that cycle, IDLE next cycle, no write; a following ADD completes normally.
REQ-035 rst asserted mid-BUSY -> all outputs 0 and IDLE next cycle; wreg=1 with wd=0 -> wreg_o=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/jump results plus a multi-cycle
// restoring divider that stalls the pipeline until its result is ready.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [16:0] link_addr_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  // Result classes (alusel_i)
  localparam logic [2:0] SelNop   = 3'd0;
  localparam logic [2:0] SelLogic = 3'd1;
  localparam logic [2:0] SelShift = 3'd2;
  localparam logic [2:0] SelArith = 3'd3;
  localparam logic [2:0] SelJump  = 3'd4;
  localparam logic [2:0] SelDiv   = 3'd5;

  // Operation codes (aluop_i[6:0]) within each class
  localparam logic [6:0] OpAnd  = 7'd0;
  localparam logic [6:0] OpOr   = 7'd1;
  localparam logic [6:0] OpXor  = 7'd2;
  localparam logic [6:0] OpLui  = 7'd3;
  localparam logic [6:0] OpSll  = 7'd0;
  localparam logic [6:0] OpSrl  = 7'd1;
  localparam logic [6:0] OpSra  = 7'd2;
  localparam logic [6:0] OpAdd  = 7'd0;
  localparam logic [6:0] OpSub  = 7'd1;
  localparam logic [6:0] OpSlt  = 7'd2;
  localparam logic [6:0] OpSltu = 7'd3;
  localparam logic [6:0] OpDiv  = 7'd0;
  localparam logic [6:0] OpRem  = 7'd2;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  logic [6:0]  op;
  logic [31:0] op_b;
  logic [4:0]  sa;
  logic [31:0] alu_res;
  logic        alu_ok;

  assign op   = aluop_i[6:0];
  assign op_b = aluop_i[7] ? imm_i : reg2_i;
  assign sa   = aluop_i[7] ? shamt_i : reg2_i[4:0];

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (alusel_i)
      SelLogic: begin
        case (op)
          OpAnd:   alu_res = reg1_i & op_b;
          OpOr:    alu_res = reg1_i | op_b;
          OpXor:   alu_res = reg1_i ^ op_b;
          OpLui:   alu_res = op_b;
          default: alu_ok = 1'b0;
        endcase
      end
      SelShift: begin
        case (op)
          OpSll:   alu_res = reg1_i << sa;
          OpSrl:   alu_res = reg1_i >> sa;
          OpSra:   alu_res = $unsigned($signed(reg1_i) >>> sa);
          default: alu_ok = 1'b0;
        endcase
      end
      SelArith: begin
        case (op)
          OpAdd:   alu_res = reg1_i + op_b;
          OpSub:   alu_res = reg1_i - op_b;
          OpSlt:   alu_res = {31'b0, $signed(reg1_i) < $signed(op_b)};
          OpSltu:  alu_res = {31'b0, reg1_i < op_b};
          default: alu_ok = 1'b0;
        endcase
      end
      SelJump: alu_res = {15'b0, link_addr_i};
      SelNop:  alu_ok = 1'b0;
      default: alu_ok = 1'b0;  // DIV is produced by the FSM; codes 6/7 are unknown
    endcase
  end

  // Divider
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        sel_rem_q, sel_rem_d;

  logic        is_div;
  logic        div_signed;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] partial;
  logic [32:0] trial;
  logic        div_stall;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_res;

  assign is_div     = (alusel_i == SelDiv) && (op < 7'd4);
  assign div_signed = (op == OpDiv) || (op == OpRem);
  assign div_zero   = (op_b == 32'h0);
  assign div_ovf    = div_signed && (reg1_i == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign a_mag      = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
  assign b_mag      = (div_signed && op_b[31]) ? -op_b : op_b;

  // The dividend shifts out of quo_q's MSB into the partial remainder.
  assign partial = {rem_q, quo_q[31]};
  assign trial   = partial - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    div_stall = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_div && !flush_i) begin
          div_stall = 1'b1;
          sel_rem_d = op[1];
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          if (div_zero) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = reg1_i;
            state_d = StDone;
          end else if (div_ovf) begin
            quo_d   = 32'h8000_0000;
            rem_d   = 32'h0;
            state_d = StDone;
          end else begin
            quo_d     = a_mag;
            rem_d     = 32'h0;
            dvs_d     = b_mag;
            cnt_d     = 6'd0;
            neg_quo_d = div_signed && (reg1_i[31] ^ op_b[31]);
            neg_rem_d = div_signed && reg1_i[31];
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        div_stall = 1'b1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = partial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign div_res = sel_rem_q ? rem_fix : quo_fix;

  logic stall;

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stall      = 1'b0;
    if (!rst) begin
      stall = div_stall && !flush_i;
      wd_o  = wd_i;
      if (state_q == StDone) begin
        wdata_o = div_res;
      end else if (alu_ok) begin
        wdata_o = alu_res;
      end
      wreg_o = wreg_i && (wd_i != 5'd0) && !flush_i && !stall &&
               ((state_q == StDone) || alu_ok);
    end
    stallreq_o = stall;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised + directed bench for ex_stage: a driver issues instructions and queues
// model results; a monitor pops and compares whenever the stage stops stalling.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i, imm_i;
  logic [4:0]  shamt_i, wd_i;
  logic        wreg_i;
  logic [16:0] link_addr_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .imm_i       (imm_i),
    .shamt_i     (shamt_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .link_addr_i (link_addr_i),
    .flush_i     (flush_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq_o  (stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  wd;
    int          stalls;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stall_cnt = 0;
  logic inst_v = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: results straight from the instruction semantics.
  function automatic exp_t model(input logic [2:0] sel, input logic [7:0] op8,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] imm, input logic [4:0] sh,
                                 input logic [4:0] wd, input logic wr,
                                 input logic [16:0] link);
    exp_t        e;
    logic [31:0] b, res, q, r;
    logic [4:0]  s;
    int          op;
    bit          valid, sgn;
    b     = op8[7] ? imm : r2;
    s     = op8[7] ? sh : r2[4:0];
    op    = int'(op8[6:0]);
    valid = 1'b1;
    res   = 32'h0;
    e.stalls = 0;
    case (sel)
      3'd1: case (op)
        0: res = r1 & b;
        1: res = r1 | b;
        2: res = r1 ^ b;
        3: res = b;
        default: valid = 1'b0;
      endcase
      3'd2: case (op)
        0: res = r1 << s;
        1: res = r1 >> s;
        2: res = (r1 >> s) | (r1[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
        default: valid = 1'b0;
      endcase
      3'd3: case (op)
        0: res = r1 + b;
        1: res = r1 - b;
        2: res = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0;
        3: res = (r1 < b) ? 32'd1 : 32'd0;
        default: valid = 1'b0;
      endcase
      3'd4: res = {15'b0, link};
      3'd5: begin
        if (op < 4) begin
          sgn = (op == 0) || (op == 2);
          if (b == 32'h0) begin
            q = 32'hFFFF_FFFF; r = r1; e.stalls = 1;
          end else if (sgn && r1 == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'h0; e.stalls = 1;
          end else begin
            e.stalls = 33;
            if (sgn) begin
              q = $signed(r1) / $signed(b);
              r = $signed(r1) % $signed(b);
            end else begin
              q = r1 / b;
              r = r1 % b;
            end
          end
          res = (op >= 2) ? r : q;
        end else begin
          valid = 1'b0;
        end
      end
      default: valid = 1'b0;
    endcase
    e.wdata    = valid ? res : 32'h0;
    e.wreg     = wr && valid && (wd != 5'd0);
    e.wd       = wd;
    e.chk_data = 1'b1;
    e.name     = "";
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t me;
    if (rst) begin
      stall_cnt = 0;
    end else if (inst_v) begin
      if (stallreq_o) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got wdata %h with no instruction expected", wdata_o);
        end else begin
          me = exp_q.pop_front();
          check({me.name, ".wd"}, 32'(wd_o), 32'(me.wd));
          check({me.name, ".wreg"}, 32'(wreg_o), 32'(me.wreg));
          check({me.name, ".stalls"}, 32'(stall_cnt), 32'(me.stalls));
          if (me.chk_data) check({me.name, ".wdata"}, wdata_o, me.wdata);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic idle_inputs();
    aluop_i = 8'h0; alusel_i = 3'd0; reg1_i = '0; reg2_i = '0; imm_i = '0;
    shamt_i = '0; wd_i = '0; wreg_i = 1'b0; link_addr_i = '0; flush_i = 1'b0;
  endtask

  // Entered and left at posedge+1. flush_at >= 0 asserts flush after that many stall cycles.
  task automatic issue(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] sh,
                       input logic [4:0] wd, input logic wr, input logic [16:0] link,
                       input int flush_at, input string name);
    exp_t e;
    bit   done;
    alusel_i = sel; aluop_i = op; reg1_i = r1; reg2_i = r2; imm_i = imm; shamt_i = sh;
    wd_i = wd; wreg_i = wr; link_addr_i = link; flush_i = 1'b0; inst_v = 1'b1;
    e = model(sel, op, r1, r2, imm, sh, wd, wr, link);
    e.name = name;
    if (flush_at >= 0) begin
      e.wreg = 1'b0; e.chk_data = 1'b0; e.stalls = flush_at;
    end
    exp_q.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (flush_at == n) flush_i = 1'b1;
      @(negedge clk);
      if (!stallreq_o) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      failures++;
      $display("FAIL %s.timeout: stallreq still 1 after 60 cycles, required release", name);
      finish_run();
    end
    @(posedge clk); #1;
    inst_v = 1'b0;
    idle_inputs();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0] rop;
    idle_inputs();
    rst = 1'b1;
    alusel_i = 3'd3; reg1_i = 32'd1; wd_i = 5'd7; wreg_i = 1'b1;
    @(negedge clk);
    check("reset.wd", 32'(wd_o), 32'h0);
    check("reset.wreg", 32'(wreg_o), 32'h0);
    check("reset.wdata", wdata_o, 32'h0);
    check("reset.stall", 32'(stallreq_o), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    issue(3'd3, 8'h80, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd0, 5'd3, 1'b1, 17'd0, -1, "add_imm");
    issue(3'd2, 8'h02, 32'h8000_0000, 32'd4, 32'd0, 5'd0, 5'd4, 1'b1, 17'd0, -1, "sra");
    issue(3'd3, 8'h03, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd5, 1'b1, 17'd0, -1, "sltu");
    issue(3'd2, 8'h80, 32'h0000_00F1, 32'd0, 32'd0, 5'd3, 5'd6, 1'b1, 17'd0, -1, "sll_shamt");
    issue(3'd1, 8'h83, 32'd9, 32'd0, 32'h1234_0000, 5'd0, 5'd7, 1'b1, 17'd0, -1, "lui");
    issue(3'd4, 8'h00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 1'b1, 17'h1ABCD, -1, "jal");
    issue(3'd0, 8'h00, 32'd3, 32'd4, 32'd0, 5'd0, 5'd8, 1'b1, 17'd0, -1, "nop");
    issue(3'd7, 8'h00, 32'd3, 32'd4, 32'd0, 5'd0, 5'd8, 1'b1, 17'd0, -1, "unknown_sel");
    issue(3'd3, 8'h00, 32'd3, 32'd4, 32'd0, 5'd0, 5'd0, 1'b1, 17'd0, -1, "add_wd0");
    issue(3'd5, 8'h00, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0, 5'd9, 1'b1, 17'd0, -1, "div_m7_2");
    issue(3'd5, 8'h02, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0, 5'd9, 1'b1, 17'd0, -1, "rem_m7_2");
    issue(3'd5, 8'h01, 32'd1234, 32'd0, 32'd0, 5'd0, 5'd10, 1'b1, 17'd0, -1, "divu_by0");
    issue(3'd5, 8'h02, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd11, 1'b1, 17'd0, -1,
          "rem_ovf");
    issue(3'd5, 8'h03, 32'hFFFF_FFFF, 32'd7, 32'd0, 5'd0, 5'd0, 1'b1, 17'd0, -1, "remu_wd0");
    issue(3'd5, 8'h00, 32'd100, 32'd7, 32'd0, 5'd0, 5'd12, 1'b1, 17'd0, 10, "div_flush");
    issue(3'd3, 8'h00, 32'd40, 32'd2, 32'd0, 5'd0, 5'd13, 1'b1, 17'd0, -1, "add_after_flush");

    // Reset in the middle of a division
    alusel_i = 3'd5; aluop_i = 8'h00; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd14;
    wreg_i = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst.wd", 32'(wd_o), 32'h0);
    check("midrst.wreg", 32'(wreg_o), 32'h0);
    check("midrst.wdata", wdata_o, 32'h0);
    check("midrst.stall", 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(3'd3, 8'h01, 32'd40, 32'd2, 32'd0, 5'd0, 5'd15, 1'b1, 17'd0, -1, "sub_after_rst");

    for (int i = 0; i < 300; i++) begin
      rop = {1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 3))};
      issue(3'($urandom_range(0, 7)), rop, pick(), pick(), pick(), 5'($urandom),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 17'($urandom),
            -1, "rand");
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    finish_run();
  end

endmodule
